// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    HOLD,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words and keeps the running
// XOR checksum of every byte it has packed since the last clear.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  byte_cnt;
  logic [23:0] lanes;

  // The lane-3 byte is combined directly, so the word is complete on the
  // same edge that accepts its last byte.
  assign word_valid = en && (byte_cnt == 2'(WORD_BYTES - 1));
  assign word       = {data, lanes};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      lanes    <= 24'd0;
      csum     <= 8'd0;
    end else if (en) begin
      byte_cnt <= byte_cnt + 2'd1;
      csum     <= csum ^ data;
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= data;
        2'd1:    lanes[15:8]  <= data;
        2'd2:    lanes[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed image over valid/ready,
// writes it to instruction memory from address 0 and then releases the core.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int             HOLD_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

  loader_state_t     state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W:0]   word_idx;
  logic [HOLD_W-1:0] hold_cnt;

  logic              xfer;
  logic              pk_en;
  logic              pk_clear;
  logic              word_valid;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic [LEN_W:0]    len_full;
  logic              last_word;

  assign xfer      = rx_valid && rx_ready;
  assign pk_en     = xfer && (state == DATA);
  assign pk_clear  = (state == LEN_LO);
  // Extra top bit so a 16-bit length can be compared against 2**ADDR_W safely.
  assign len_full  = {1'b0, rx_data, len[7:0]};
  assign last_word = (LEN_W'(word_idx) + LEN_W'(1)) == len;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .en         (pk_en),
    .data       (rx_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN_LO;
      len        <= '0;
      word_idx   <= '0;
      hold_cnt   <= '0;
      rx_ready   <= 1'b1;
      cpu_reset  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN_LO: if (xfer) begin
          len[7:0] <= rx_data;
          state    <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          len[15:8] <= rx_data;
          if (len_full == '0 || len_full > MAX_LEN) begin
            state    <= ERR;
            rx_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (word_valid) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx[ADDR_W-1:0];
          imem_wdata <= word;
          word_idx   <= word_idx + 1'b1;
          if (last_word) state <= CHK;
        end
        CHK: if (xfer) begin
          rx_ready <= 1'b0;
          if (rx_data == csum) begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(RST_HOLD - 1);
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
